bus_read_decoder: RTL and testbench
===================================

# bus_read_decoder

Tester-side receiver for the RK05 read interface, sitting directly downstream of the emulator's read-data serializer. It samples the bus read clock and read data pulse lines and locates the all-zeros preamble and the sync bit. It then deserializes LSB-first 16-bit data words plus the trailing CRC word and presents each word on a one-cycle strobe to the tester's capture buffer. It also checks the CRC and reports framing errors.

## Interface
Parameters:
- CLK_LOST_CYCLES, 2048, clock cycles with no read-clock edge while receiving before declaring clock loss
- SYNC_STAGES, 2, synchronizer depth for the bus inputs (minimum 2)

Ports:
- clock  input  1  master clock, 40 MHz
- reset_l  input  1  asynchronous, active-low reset
- rd_gate  input  1  tester's read gate; high = receive enabled
- BUS_RD_CLK_H  input  1  bus read clock pulses (asynchronous)
- BUS_RD_DATA_H  input  1  bus read data pulses (asynchronous)
- data_length  input  16  data+CRC field length in bits; word count = data_length[15:4]
- min_preamble  input  8  minimum accepted preamble zero-bit count
- word_data  output  16  received word, stable from word_valid until the next word_valid
- word_valid  output  1  one-cycle strobe per received word (data and CRC words)
- word_is_crc  output  1  qualifies word_valid: high for the final (CRC) word
- sector_done  output  1  one-cycle strobe after the CRC word
- crc_ok  output  1  result of the last completed sector, valid from sector_done until the next sync
- err_preamble_short  output  1  sticky; cleared when rd_gate rises
- err_clk_lost  output  1  sticky; cleared when rd_gate rises
- err_abort  output  1  sticky, gate dropped mid-sector; cleared when rd_gate rises
- rx_active  output  1  high in PREAMBLE or DATA

## Operation
- Both bus inputs pass through SYNC_STAGES flops, then a rising-edge detect, giving clk_edge and data_edge single-cycle events.
- Bit windows:
  - A window is the interval between consecutive clk_edge events.
  - data_hit sets on data_edge.
  - At each clk_edge the bit value = data_hit, or data_edge if it coincides with that clk_edge. data_hit then clears.
  - The first clk_edge after entering PREAMBLE only opens a window and commits no bit.
- States: IDLE, PREAMBLE, DATA, DONE.
- IDLE:
  - Holds outputs quiet.
  - On rd_gate high: clear sticky errors, zero the preamble count, arm the first window, go to PREAMBLE.
- PREAMBLE:
  - Each committed 0 increments pre_cnt, saturating at 255.
  - A committed 1 (sync bit):
    - If pre_cnt >= min_preamble: go to DATA, crc <= 0, bit_cnt <= 0, words_left <= max(data_length[15:4], 2).
    - Otherwise: set err_preamble_short, zero pre_cnt, stay in PREAMBLE.
- DATA:
  - Each committed bit: shreg <= {bit, shreg[15:1]}.
  - Data words only (words_left != 1) also update the CRC: crc <= (crc >> 1) ^ ((crc[0] ^ bit) ? 16'hA001 : 0). This is CRC-16, reflected, init 0.
  - On the 16th bit: word_data <= shifted value, word_valid pulses, words_left decrements.
  - On the final word (words_left == 1): word_is_crc = 1, crc_ok <= (received word == crc), sector_done pulses, go to DONE.
- DONE: wait for rd_gate low, then IDLE. Further pulses are ignored.
- Gate drop: rd_gate low in PREAMBLE returns to IDLE silently. rd_gate low in DATA sets err_abort and returns to IDLE with no sector_done; crc_ok is unchanged.
- Clock loss: in PREAMBLE or DATA, an idle counter resets on every clk_edge. When it reaches CLK_LOST_CYCLES: set err_clk_lost, go to DONE.

## Timing
- Reset values: word_data = 0, crc_ok = 0, all strobes, errors and rx_active = 0, state = IDLE.
- Reset is asynchronous and may occur mid-sector. On release the block waits in IDLE; a gate already high starts a fresh sector on the first clock after release.
- Latency: a bus clock rising edge becomes clk_edge SYNC_STAGES+1 clocks later. word_valid and sector_done assert 1 clock after that clk_edge.
- word_valid and sector_done are each exactly 1 cycle. For the CRC word they assert in the same cycle.
- Simultaneous rd_gate fall and final clk_edge: the gate wins, giving err_abort and no sector_done.
- data_edge coinciding with clk_edge belongs to the window being closed.

## Test plan
- Preamble 32 zeros, sync, data_length=4112 (256 words + CRC), all data 0x0000, CRC word 0x0000, min_preamble=16:
  - 257 word_valid pulses.
  - Word 257 has word_is_crc=1.
  - sector_done once; crc_ok=1.
- Same stimulus with CRC word 0x0001: crc_ok=0, sector_done still pulses, no error flags.
- Preamble of 8 zeros then sync, min_preamble=16:
  - err_preamble_short=1, no word_valid.
  - A following 32-zero preamble with sync decodes normally.
- LSB-first check, data_length=32:
  - Serialized word 0xA5C3 yields word_data=0xA5C3.
  - The bench's reference CRC word yields crc_ok=1.
- Drop rd_gate after 100 words: err_abort=1, no sector_done, rx_active=0 within 2 clocks.
- Stop bus clocks mid-word with the gate held high:
  - err_clk_lost=1 exactly CLK_LOST_CYCLES clocks after the last clk_edge.
  - Reasserting the gate clears all errors.

Source files
------------

// File: rtl/bus_read_decoder.sv
// RK05 read-interface receiver: finds preamble and sync bit, deserializes LSB-first words and checks CRC-16.
// Latency: bus clock edge -> SYNC_STAGES+1 clocks -> bit commit; word strobes 1 clock later. No backpressure.
module bus_read_decoder #(
  parameter int CLK_LOST_CYCLES = 2048,
  parameter int SYNC_STAGES     = 2
) (
  input  logic        clock,
  input  logic        reset_l,
  input  logic        rd_gate,
  input  logic        BUS_RD_CLK_H,
  input  logic        BUS_RD_DATA_H,
  input  logic [15:0] data_length,
  input  logic [7:0]  min_preamble,
  output logic [15:0] word_data,
  output logic        word_valid,
  output logic        word_is_crc,
  output logic        sector_done,
  output logic        crc_ok,
  output logic        err_preamble_short,
  output logic        err_clk_lost,
  output logic        err_abort,
  output logic        rx_active
);

  localparam int IDLE_W = $clog2(CLK_LOST_CYCLES + 1);
  localparam logic [IDLE_W-1:0] LOST_M1  = IDLE_W'(CLK_LOST_CYCLES - 1);
  localparam logic [IDLE_W-1:0] LOST_SAT = IDLE_W'(CLK_LOST_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_DONE} state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
  logic clk_prev_q, data_prev_q, clk_edge_q, clk_edge_d, data_edge_q, data_edge_d;

  state_t      state_q, state_d;
  logic [7:0]  pre_cnt_q, pre_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [11:0] words_left_q, words_left_d;
  logic [15:0] shreg_q, shreg_d, crc_q, crc_d, word_data_q, word_data_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic data_hit_q, data_hit_d, first_q, first_d;
  logic word_valid_q, word_valid_d, word_is_crc_q, word_is_crc_d;
  logic sector_done_q, sector_done_d, crc_ok_q, crc_ok_d;
  logic err_short_q, err_short_d, err_lost_q, err_lost_d, err_abort_q, err_abort_d;

  logic        bit_val, commit, lost, fb;
  logic [15:0] shifted, crc_next;
  logic [11:0] wl_init;
  logic        unused_len_bits;

  assign unused_len_bits = ^data_length[3:0];

  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], BUS_RD_CLK_H};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], BUS_RD_DATA_H};
    clk_edge_d  = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
    data_edge_d = data_sync_q[SYNC_STAGES-1] & ~data_prev_q;
  end

  always_comb begin
    state_d       = state_q;
    pre_cnt_d     = pre_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    words_left_d  = words_left_q;
    shreg_d       = shreg_q;
    crc_d         = crc_q;
    word_data_d   = word_data_q;
    word_valid_d  = 1'b0;
    word_is_crc_d = 1'b0;
    sector_done_d = 1'b0;
    crc_ok_d      = crc_ok_q;
    err_short_d   = err_short_q;
    err_lost_d    = err_lost_q;
    err_abort_d   = err_abort_q;

    // A data edge landing with the clock edge belongs to the window being closed.
    bit_val  = data_hit_q | data_edge_q;
    commit   = clk_edge_q & ~first_q;
    shifted  = {bit_val, shreg_q[15:1]};
    fb       = crc_q[0] ^ bit_val;
    crc_next = (crc_q >> 1) ^ (fb ? 16'hA001 : 16'h0000);
    wl_init  = (data_length[15:4] < 12'd2) ? 12'd2 : data_length[15:4];
    lost     = ~clk_edge_q && (idle_cnt_q == LOST_M1);

    data_hit_d = clk_edge_q ? 1'b0 : (data_hit_q | data_edge_q);
    first_d    = clk_edge_q ? 1'b0 : first_q;
    if (clk_edge_q)
      idle_cnt_d = IDLE_W'(1);
    else if (idle_cnt_q != LOST_SAT)
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    else
      idle_cnt_d = idle_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (rd_gate) begin
          err_short_d = 1'b0;
          err_lost_d  = 1'b0;
          err_abort_d = 1'b0;
          pre_cnt_d   = 8'd0;
          first_d     = 1'b1;
          data_hit_d  = 1'b0;
          idle_cnt_d  = '0;
          state_d     = S_PREAMBLE;
        end
      end
      S_PREAMBLE: begin
        if (!rd_gate) begin
          state_d = S_IDLE;
        end else if (lost) begin
          err_lost_d = 1'b1;
          state_d    = S_DONE;
        end else if (commit) begin
          if (bit_val) begin
            if (pre_cnt_q >= min_preamble) begin
              state_d      = S_DATA;
              crc_d        = 16'h0000;
              bit_cnt_d    = 4'd0;
              words_left_d = wl_init;
            end else begin
              err_short_d = 1'b1;
              pre_cnt_d   = 8'd0;
            end
          end else if (pre_cnt_q != 8'hFF) begin
            pre_cnt_d = pre_cnt_q + 8'd1;
          end
        end
      end
      S_DATA: begin
        if (!rd_gate) begin
          err_abort_d = 1'b1;
          state_d     = S_IDLE;
        end else if (lost) begin
          err_lost_d = 1'b1;
          state_d    = S_DONE;
        end else if (commit) begin
          shreg_d   = shifted;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (words_left_q != 12'd1)
            crc_d = crc_next;
          if (bit_cnt_q == 4'd15) begin
            word_data_d  = shifted;
            word_valid_d = 1'b1;
            words_left_d = words_left_q - 12'd1;
            if (words_left_q == 12'd1) begin
              word_is_crc_d = 1'b1;
              crc_ok_d      = (shifted == crc_q);
              sector_done_d = 1'b1;
              state_d       = S_DONE;
            end
          end
        end
      end
      default: begin
        if (!rd_gate)
          state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      clk_sync_q    <= '0;
      data_sync_q   <= '0;
      clk_prev_q    <= 1'b0;
      data_prev_q   <= 1'b0;
      clk_edge_q    <= 1'b0;
      data_edge_q   <= 1'b0;
      state_q       <= S_IDLE;
      pre_cnt_q     <= 8'd0;
      bit_cnt_q     <= 4'd0;
      words_left_q  <= 12'd0;
      shreg_q       <= 16'h0000;
      crc_q         <= 16'h0000;
      word_data_q   <= 16'h0000;
      idle_cnt_q    <= '0;
      data_hit_q    <= 1'b0;
      first_q       <= 1'b0;
      word_valid_q  <= 1'b0;
      word_is_crc_q <= 1'b0;
      sector_done_q <= 1'b0;
      crc_ok_q      <= 1'b0;
      err_short_q   <= 1'b0;
      err_lost_q    <= 1'b0;
      err_abort_q   <= 1'b0;
    end else begin
      clk_sync_q    <= clk_sync_d;
      data_sync_q   <= data_sync_d;
      clk_prev_q    <= clk_sync_q[SYNC_STAGES-1];
      data_prev_q   <= data_sync_q[SYNC_STAGES-1];
      clk_edge_q    <= clk_edge_d;
      data_edge_q   <= data_edge_d;
      state_q       <= state_d;
      pre_cnt_q     <= pre_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      words_left_q  <= words_left_d;
      shreg_q       <= shreg_d;
      crc_q         <= crc_d;
      word_data_q   <= word_data_d;
      idle_cnt_q    <= idle_cnt_d;
      data_hit_q    <= data_hit_d;
      first_q       <= first_d;
      word_valid_q  <= word_valid_d;
      word_is_crc_q <= word_is_crc_d;
      sector_done_q <= sector_done_d;
      crc_ok_q      <= crc_ok_d;
      err_short_q   <= err_short_d;
      err_lost_q    <= err_lost_d;
      err_abort_q   <= err_abort_d;
    end
  end

  assign word_data          = word_data_q;
  assign word_valid         = word_valid_q;
  assign word_is_crc        = word_is_crc_q;
  assign sector_done        = sector_done_q;
  assign crc_ok             = crc_ok_q;
  assign err_preamble_short = err_short_q;
  assign err_clk_lost       = err_lost_q;
  assign err_abort          = err_abort_q;
  assign rx_active          = (state_q == S_PREAMBLE) || (state_q == S_DATA);

endmodule

// File: tb/tb_bus_read_decoder.sv
// Scoreboard bench for bus_read_decoder: stimulus pushes expected words, a monitor pops on word_valid.
module tb_bus_read_decoder;
  localparam int LOST = 64;
  localparam int SYNC = 2;

  logic        clock = 1'b0;
  logic        reset_l, rd_gate, bus_clk, bus_data;
  logic [15:0] data_length;
  logic [7:0]  min_preamble;
  logic [15:0] word_data;
  logic        word_valid, word_is_crc, sector_done, crc_ok;
  logic        err_preamble_short, err_clk_lost, err_abort, rx_active;

  typedef struct packed {
    logic [15:0] dat;
    logic        is_crc;
  } exp_t;

  exp_t exp_q[$];
  bit   ok_q[$];
  int   cmp_cnt = 0;
  int   err_cnt = 0;
  int   sd_cnt  = 0;

  always #5 clock = ~clock;

  bus_read_decoder #(.CLK_LOST_CYCLES(LOST), .SYNC_STAGES(SYNC)) dut (
    .clock(clock), .reset_l(reset_l), .rd_gate(rd_gate),
    .BUS_RD_CLK_H(bus_clk), .BUS_RD_DATA_H(bus_data),
    .data_length(data_length), .min_preamble(min_preamble),
    .word_data(word_data), .word_valid(word_valid), .word_is_crc(word_is_crc),
    .sector_done(sector_done), .crc_ok(crc_ok),
    .err_preamble_short(err_preamble_short), .err_clk_lost(err_clk_lost),
    .err_abort(err_abort), .rx_active(rx_active)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_of(input logic [15:0] w);
    logic [15:0] c;
    logic        f;
    c = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      f = c[0] ^ w[i];
      c = c >> 1;
      if (f) c = c ^ 16'hA001;
    end
    return c;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_bit(input logic b);
    bus_data = b; cyc(1);
    bus_data = 1'b0; cyc(1);
    bus_clk = 1'b1; cyc(2);
    bus_clk = 1'b0; cyc(1);
  endtask

  task automatic send_word(input logic [15:0] w, input logic is_crc);
    exp_t e;
    e.dat = w;
    e.is_crc = is_crc;
    exp_q.push_back(e);
    for (int i = 0; i < 16; i++) send_bit(w[i]);
  endtask

  task automatic send_preamble(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
    send_bit(1'b1);
  endtask

  task automatic start_gate();
    rd_gate = 1'b1; cyc(2);
    bus_clk = 1'b1; cyc(2);
    bus_clk = 1'b0; cyc(2);
  endtask

  task automatic end_gate();
    rd_gate = 1'b0; cyc(3);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) cyc(1);
    cyc(4);
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    exp_t e;
    bit   seen;
    int   n;
    reset_l = 1'b0; rd_gate = 1'b0; bus_clk = 1'b0; bus_data = 1'b0;
    data_length = 16'd4112; min_preamble = 8'd16;

    fork
      forever begin
        @(negedge clock);
        if (word_valid) begin
          if (exp_q.size() == 0) begin
            cmp_cnt++; err_cnt++;
            $display("FAIL unexpected_word: got 0x%0h expected none", word_data);
          end else begin
            e = exp_q.pop_front();
            check("word_data", word_data, e.dat);
            check("word_is_crc", word_is_crc, e.is_crc);
          end
        end
        if (sector_done) begin
          sd_cnt++;
          check("sd_with_crc_word", {word_valid, word_is_crc}, 2'b11);
          if (ok_q.size() == 0) begin
            cmp_cnt++; err_cnt++;
            $display("FAIL unexpected_sector_done: got 1 expected 0");
          end else begin
            check("crc_ok", crc_ok, ok_q.pop_front());
          end
        end
      end
    join_none

    cyc(3);
    check("rst_word_data", word_data, 0);
    check("rst_word_valid", word_valid, 0);
    check("rst_sector_done", sector_done, 0);
    check("rst_crc_ok", crc_ok, 0);
    check("rst_errs", {err_preamble_short, err_clk_lost, err_abort}, 0);
    check("rst_rx_active", rx_active, 0);
    reset_l = 1'b1; cyc(2);

    // Full sector of zeros with a correct CRC
    start_gate();
    check("rx_active_pre", rx_active, 1);
    send_preamble(32);
    for (int i = 0; i < 256; i++) send_word(16'h0000, 1'b0);
    ok_q.push_back(1'b1);
    send_word(16'h0000, 1'b1);
    wait_drain("drain_t1");
    check("t1_sectors", sd_cnt, 1);
    check("t1_errs", {err_preamble_short, err_clk_lost, err_abort}, 0);
    check("t1_rx_active_done", rx_active, 0);
    end_gate();

    // Same sector with a corrupted CRC word
    start_gate();
    send_preamble(32);
    for (int i = 0; i < 256; i++) send_word(16'h0000, 1'b0);
    ok_q.push_back(1'b0);
    send_word(16'h0001, 1'b1);
    wait_drain("drain_t2");
    check("t2_sectors", sd_cnt, 2);
    check("t2_errs", {err_preamble_short, err_clk_lost, err_abort}, 0);
    end_gate();

    // Short preamble, then a good one; LSB-first word
    data_length = 16'd32;
    start_gate();
    send_preamble(8);
    cyc(6);
    check("t3_short_err", err_preamble_short, 1);
    check("t3_still_rx", rx_active, 1);
    send_preamble(32);
    send_word(16'hA5C3, 1'b0);
    ok_q.push_back(1'b1);
    send_word(crc_of(16'hA5C3), 1'b1);
    wait_drain("drain_t3");
    check("t3_sectors", sd_cnt, 3);
    check("t3_short_sticky", err_preamble_short, 1);
    end_gate();

    // data_length below two words and preamble exactly at the minimum
    data_length = 16'd16;
    start_gate();
    check("t4_err_cleared", err_preamble_short, 0);
    send_preamble(16);
    send_word(16'h0001, 1'b0);
    ok_q.push_back(1'b1);
    send_word(crc_of(16'h0001), 1'b1);
    wait_drain("drain_t4");
    check("t4_sectors", sd_cnt, 4);
    check("t4_short_none", err_preamble_short, 0);
    end_gate();

    // Gate dropped mid-sector after 100 words
    data_length = 16'd4112;
    start_gate();
    send_preamble(32);
    for (int i = 0; i < 100; i++) send_word(16'(i * 16'h0101) ^ 16'h5A5A, 1'b0);
    cyc(6);
    rd_gate = 1'b0; cyc(2);
    check("t5_rx_active", rx_active, 0);
    check("t5_abort", err_abort, 1);
    check("t5_sectors", sd_cnt, 4);
    check("t5_pending", exp_q.size(), 0);
    cyc(3);

    // Bus clock stops mid-word
    data_length = 16'd32;
    start_gate();
    check("t6_abort_cleared", err_abort, 0);
    send_preamble(32);
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    cyc(2);
    bus_clk = 1'b1;
    seen = 1'b0;
    n = 0;
    while (n < LOST + SYNC + 40 && !seen) begin
      @(posedge clock);
      n++;
      #1;
      if (n == 2) bus_clk = 1'b0;
      if (err_clk_lost) seen = 1'b1;
    end
    check("t6_lost_seen", seen, 1);
    check("t6_lost_latency", n, LOST + SYNC + 1);
    cyc(1);
    check("t6_rx_active", rx_active, 0);
    rd_gate = 1'b0; cyc(3);
    check("t6_lost_sticky", err_clk_lost, 1);
    rd_gate = 1'b1; cyc(2);
    check("t6_errs_cleared", {err_preamble_short, err_clk_lost, err_abort}, 0);
    check("t6_rx_again", rx_active, 1);
    rd_gate = 1'b0; cyc(3);

    check("final_sectors", sd_cnt, 4);
    check("final_exp_q", exp_q.size(), 0);
    check("final_ok_q", ok_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
